// File: rtl/palt_nios_sys_nios_oci_dct_packer_if.sv
// rtl/palt_nios_sys_nios_oci_dct_packer_if.sv - code input and frame output handshake bundle
interface palt_nios_sys_nios_oci_dct_packer_if;
  logic        code_valid;
  logic [1:0]  dct_code;
  logic        flush;
  logic        frame_ready;
  logic        frame_valid;
  logic [35:0] frame_data;

  modport master (
    output code_valid, dct_code, flush, frame_ready,
    input  frame_valid, frame_data
  );

  modport slave (
    input  code_valid, dct_code, flush, frame_ready,
    output frame_valid, frame_data
  );
endinterface

// File: rtl/palt_nios_sys_nios_oci_dct_packer.sv
// rtl/palt_nios_sys_nios_oci_dct_packer.sv - packs 2-bit DCT trace codes into 36-bit frames
// Optional saturating overflow counter on ovf_count when PALT_NIOS_DCT_OVF_CNT_EN is defined.
module palt_nios_sys_nios_oci_dct_packer #(
  parameter int MAX_CODES = 15,
  parameter int OVF_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trc_on,
  palt_nios_sys_nios_oci_dct_packer_if.slave bus,
  output logic [2*MAX_CODES-1:0] dct_buffer,
  output logic [3:0]             dct_count,
  output logic                   dct_ovf
`ifdef PALT_NIOS_DCT_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]   ovf_count
`endif
);
  localparam int         BUF_W = 2 * MAX_CODES;
  localparam logic [3:0] FULL  = 4'(MAX_CODES);

  typedef enum logic [1:0] {S_DISABLED, S_COLLECT, S_DRAIN} state_t;

  state_t             state, state_n;
  logic               slot_free, full, flush_req, flush_pend;
  logic               form, drop, pend_n;
  logic [BUF_W-1:0]   buf_n, frm_buf;
  logic [3:0]         cnt_n, frm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_DISABLED;
    else          state <= state_n;
  end

  // Drain lingers only while a partial buffer waits for the output slot.
  always_comb begin
    state_n = state;
    case (state)
      S_DISABLED: if (trc_on) state_n = S_COLLECT;
      S_COLLECT:  if (!trc_on) state_n = S_DRAIN;
      S_DRAIN:    if (dct_count == 4'd0 || slot_free) state_n = S_DISABLED;
      default:    state_n = S_DISABLED;
    endcase
  end

  always_comb begin
    slot_free = !bus.frame_valid || bus.frame_ready;
    full      = (dct_count == FULL);
    flush_req = bus.flush || flush_pend;
    drop      = 1'b0;
    form      = 1'b0;
    pend_n    = 1'b0;
    buf_n     = dct_buffer;
    cnt_n     = dct_count;
    frm_buf   = dct_buffer;
    frm_cnt   = dct_count;
    case (state)
      S_COLLECT: begin
        if (bus.code_valid) begin
          if (full && !slot_free) begin
            drop = 1'b1;
          end else if (full) begin
            // Deferred full frame leaves now; the new code opens the next buffer.
            form  = 1'b1;
            buf_n = {{(BUF_W-2){1'b0}}, bus.dct_code};
            cnt_n = 4'd1;
          end else begin
            buf_n = {dct_buffer[BUF_W-3:0], bus.dct_code};
            cnt_n = dct_count + 4'd1;
          end
        end
        if (!form) begin
          frm_buf = buf_n;
          frm_cnt = cnt_n;
          if (slot_free && (cnt_n == FULL || (flush_req && cnt_n != 4'd0))) begin
            form  = 1'b1;
            buf_n = '0;
            cnt_n = 4'd0;
          end else begin
            pend_n = flush_req && (cnt_n != 4'd0);
          end
        end
      end
      S_DRAIN: begin
        if (dct_count != 4'd0 && slot_free) begin
          form  = 1'b1;
          buf_n = '0;
          cnt_n = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer      <= '0;
      dct_count       <= 4'd0;
      flush_pend      <= 1'b0;
      dct_ovf         <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.frame_data  <= '0;
    end else begin
      dct_buffer <= buf_n;
      dct_count  <= cnt_n;
      flush_pend <= pend_n;
      dct_ovf    <= drop;
      if (form) begin
        bus.frame_valid <= 1'b1;
        bus.frame_data  <= {2'b10, frm_cnt, frm_buf};
      end else if (bus.frame_ready) begin
        bus.frame_valid <= 1'b0;
      end
    end
  end

`ifdef PALT_NIOS_DCT_OVF_CNT_EN
  logic trc_on_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trc_on_q  <= 1'b0;
      ovf_count <= '0;
    end else begin
      trc_on_q <= trc_on;
      if (trc_on && !trc_on_q)
        ovf_count <= '0;
      else if (drop && !(&ovf_count))
        ovf_count <= ovf_count + 1'b1;
    end
  end
`endif

endmodule
